operand2_shifter_pipe: RTL and testbench

Pipelined, width-parametrised successor to the combinational ARM operand-2 barrel shifter. It sits between register read and the ALU in the execute path. It supports three operand-2 sources:
- immediate-amount shift
- register-amount shift, with the full 8-bit amount semantics
- rotated 8-bit immediate

Transfers use valid/ready handshakes on both sides, and a sideband tag passes through unchanged.

---
 rtl/operand2_shifter_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_operand2_shifter_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand2_shifter_pipe.sv
// ---------------------------------------------------------------------------
// operand2_shifter_pipe
//
// Pipelined ARM operand-2 barrel shifter, placed between register read and
// the ALU. It handles three operand-2 sources (immediate-amount shift,
// register-amount shift with full 8-bit amount semantics, rotated 8-bit
// immediate) plus a plain pass-through mode. Both sides use valid/ready
// handshakes, and a sideband tag travels alongside each result.
//
// Optional build macro: SHIFTER_MID_REG_EN
//   undefined : one register stage, 1-cycle latency
//   defined   : amount decode and shift network are split by a register
//               stage, giving 2-cycle latency. Throughput and results are
//               the same in both builds.
//
// Ports:
//   in_Clk, in_Reset           clock (rising edge), async active-high reset
//   in_Valid / out_Ready       upstream handshake
//   in_Mode                    00 imm-shift, 01 reg-shift, 10 imm-rotate,
//                              11 pass-through
//   in_Shift_type              00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_Reg_val                 value to shift
//   in_Shift_imm               immediate shift amount (AW bits)
//   in_Shift_reg               register shift amount (bottom byte of Rs)
//   in_Imm8, in_Rotate         8-bit immediate, rotated right by 2*in_Rotate
//   in_C_flag                  current carry flag
//   in_Tag                     sideband tag, passed through unchanged
//   out_Valid / in_Ready       downstream handshake
//   out_Op2, out_Carry, out_Tag  result, shifter carry-out, matching tag
// ---------------------------------------------------------------------------
module operand2_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                       in_Clk,
    input  logic                       in_Reset,
    input  logic                       in_Valid,
    output logic                       out_Ready,
    input  logic [1:0]                 in_Mode,
    input  logic [1:0]                 in_Shift_type,
    input  logic [WIDTH-1:0]           in_Reg_val,
    input  logic [$clog2(WIDTH)-1:0]   in_Shift_imm,
    input  logic [7:0]                 in_Shift_reg,
    input  logic [7:0]                 in_Imm8,
    input  logic [3:0]                 in_Rotate,
    input  logic                       in_C_flag,
    input  logic [TAG_W-1:0]           in_Tag,
    output logic                       out_Valid,
    input  logic                       in_Ready,
    output logic [WIDTH-1:0]           out_Op2,
    output logic                       out_Carry,
    output logic [TAG_W-1:0]           out_Tag
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [8:0] W9 = 9'(WIDTH);

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;

    localparam logic [1:0] M_IMM_SHIFT = 2'b00;
    localparam logic [1:0] M_REG_SHIFT = 2'b01;
    localparam logic [1:0] M_IMM_ROT   = 2'b10;

    // The decode step reduces every mode/type/amount combination to one of
    // these primitive operations. Amounts carried with LSL/LSR/ASR/ROR are
    // always already inside 0..WIDTH-1, so the shift network never has to
    // deal with out-of-range amounts.
    typedef enum logic [2:0] {
        OP_PASS,    // result = value, carry = cbit
        OP_LSL,     // logical left by amt, carry = last bit out
        OP_LSR,     // logical right by amt, carry = last bit out
        OP_ASR,     // arithmetic right by amt, carry = last bit out
        OP_ROR,     // rotate right by amt, carry = result msb
        OP_RRX,     // rotate right through carry, cbit enters at msb
        OP_ZERO,    // result = 0, carry = cbit
        OP_FILL     // result = all sign bits, carry = sign bit
    } op_t;

    op_t              dec_op;
    logic [WIDTH-1:0] dec_value;
    logic [AW-1:0]    dec_amt;
    logic             dec_cbit;
    logic [8:0]       n_full;
    logic             use_rules;
    logic [5:0]       rot2;

    op_t              net_op;
    logic [WIDTH-1:0] net_value;
    logic [AW-1:0]    net_amt;
    logic             net_cbit;
    logic [WIDTH-1:0] net_res;
    logic             net_carry;
    logic [WIDTH:0]   wide;
    logic [2*WIDTH-1:0] dbl;

    // The rotate field counts in steps of two; since WIDTH is a power of two
    // the "mod WIDTH" is just the low AW bits.
    assign rot2 = {1'b0, in_Rotate, 1'b0};

    // Amount decode and special-case selection. Immediate #0 encodings are
    // first mapped to their real meaning (LSR/ASR #0 mean #WIDTH, ROR #0 is
    // RRX), then immediate and register amounts share the same rules with the
    // full 9-bit amount compared against WIDTH.
    always_comb begin
        dec_op    = OP_PASS;
        dec_value = in_Reg_val;
        dec_amt   = '0;
        dec_cbit  = in_C_flag;
        n_full    = '0;
        use_rules = 1'b0;

        case (in_Mode)
            M_IMM_SHIFT: begin
                if (in_Shift_imm == '0) begin
                    case (in_Shift_type)
                        T_LSR, T_ASR: begin
                            n_full    = W9;
                            use_rules = 1'b1;
                        end
                        T_ROR: begin
                            dec_op = OP_RRX;
                        end
                        default: ;
                    endcase
                end else begin
                    n_full    = 9'(in_Shift_imm);
                    use_rules = 1'b1;
                end
            end
            M_REG_SHIFT: begin
                n_full    = {1'b0, in_Shift_reg};
                use_rules = 1'b1;
            end
            M_IMM_ROT: begin
                dec_value = WIDTH'(in_Imm8);
                if (in_Rotate != 4'd0) begin
                    dec_op  = OP_ROR;
                    dec_amt = rot2[AW-1:0];
                end
            end
            default: ;
        endcase

        if (use_rules && (n_full != 9'd0)) begin
            case (in_Shift_type)
                T_LSL: begin
                    if (n_full < W9) begin
                        dec_op  = OP_LSL;
                        dec_amt = n_full[AW-1:0];
                    end else begin
                        dec_op   = OP_ZERO;
                        dec_cbit = (n_full == W9) ? in_Reg_val[0] : 1'b0;
                    end
                end
                T_LSR: begin
                    if (n_full < W9) begin
                        dec_op  = OP_LSR;
                        dec_amt = n_full[AW-1:0];
                    end else begin
                        dec_op   = OP_ZERO;
                        dec_cbit = (n_full == W9) ? in_Reg_val[WIDTH-1] : 1'b0;
                    end
                end
                T_ASR: begin
                    if (n_full < W9) begin
                        dec_op  = OP_ASR;
                        dec_amt = n_full[AW-1:0];
                    end else begin
                        dec_op = OP_FILL;
                    end
                end
                default: begin
                    // Rotating by a multiple of WIDTH leaves the value alone
                    // but still reports the msb as carry.
                    if (n_full[AW-1:0] == '0) begin
                        dec_op   = OP_PASS;
                        dec_cbit = in_Reg_val[WIDTH-1];
                    end else begin
                        dec_op  = OP_ROR;
                        dec_amt = n_full[AW-1:0];
                    end
                end
            endcase
        end
    end

    // Shift network. The extra bit in 'wide' catches the last bit shifted out,
    // which is exactly the ARM carry for in-range LSL/LSR/ASR. Rotation uses a
    // doubled copy of the value so an amount of zero needs no special case.
    always_comb begin
        net_res   = net_value;
        net_carry = net_cbit;
        wide      = '0;
        dbl       = '0;
        case (net_op)
            OP_LSL: begin
                wide      = {1'b0, net_value} << net_amt;
                net_res   = wide[WIDTH-1:0];
                net_carry = wide[WIDTH];
            end
            OP_LSR: begin
                wide      = {net_value, 1'b0} >> net_amt;
                net_res   = wide[WIDTH:1];
                net_carry = wide[0];
            end
            OP_ASR: begin
                wide      = $signed({net_value, 1'b0}) >>> net_amt;
                net_res   = wide[WIDTH:1];
                net_carry = wide[0];
            end
            OP_ROR: begin
                dbl       = {net_value, net_value} >> net_amt;
                net_res   = dbl[WIDTH-1:0];
                net_carry = dbl[WIDTH-1];
            end
            OP_RRX: begin
                net_res   = {net_cbit, net_value[WIDTH-1:1]};
                net_carry = net_value[0];
            end
            OP_ZERO: begin
                net_res   = '0;
                net_carry = net_cbit;
            end
            OP_FILL: begin
                net_res   = {WIDTH{net_value[WIDTH-1]}};
                net_carry = net_value[WIDTH-1];
            end
            default: ;
        endcase
    end

`ifdef SHIFTER_MID_REG_EN

    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_value;
    logic [AW-1:0]    s1_amt;
    logic             s1_cbit;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_ready;

    // Each stage can take new data when it is empty or its contents are
    // leaving this cycle.
    assign s2_ready  = !out_Valid || in_Ready;
    assign out_Ready = !s1_valid || s2_ready;

    assign net_op    = s1_op;
    assign net_value = s1_value;
    assign net_amt   = s1_amt;
    assign net_cbit  = s1_cbit;

    // Stage 1 holds the decoded operation until the output stage frees up.
    always_ff @(posedge in_Clk or posedge in_Reset) begin
        if (in_Reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_PASS;
            s1_value <= '0;
            s1_amt   <= '0;
            s1_cbit  <= 1'b0;
            s1_tag   <= '0;
        end else if (in_Valid && out_Ready) begin
            s1_valid <= 1'b1;
            s1_op    <= dec_op;
            s1_value <= dec_value;
            s1_amt   <= dec_amt;
            s1_cbit  <= dec_cbit;
            s1_tag   <= in_Tag;
        end else if (s2_ready) begin
            s1_valid <= 1'b0;
        end
    end

    // Output stage: takes the shifted result whenever it is free to move;
    // while stalled the outputs hold their value.
    always_ff @(posedge in_Clk or posedge in_Reset) begin
        if (in_Reset) begin
            out_Valid <= 1'b0;
            out_Op2   <= '0;
            out_Carry <= 1'b0;
            out_Tag   <= '0;
        end else if (s2_ready) begin
            out_Valid <= s1_valid;
            if (s1_valid) begin
                out_Op2   <= net_res;
                out_Carry <= net_carry;
                out_Tag   <= s1_tag;
            end
        end
    end

`else

    assign out_Ready = !out_Valid || in_Ready;

    assign net_op    = dec_op;
    assign net_value = dec_value;
    assign net_amt   = dec_amt;
    assign net_cbit  = dec_cbit;

    // Single output stage: load on accept, drop valid once the result has
    // been taken and nothing new arrives; hold everything while stalled.
    always_ff @(posedge in_Clk or posedge in_Reset) begin
        if (in_Reset) begin
            out_Valid <= 1'b0;
            out_Op2   <= '0;
            out_Carry <= 1'b0;
            out_Tag   <= '0;
        end else if (in_Valid && out_Ready) begin
            out_Valid <= 1'b1;
            out_Op2   <= net_res;
            out_Carry <= net_carry;
            out_Tag   <= in_Tag;
        end else if (in_Ready) begin
            out_Valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_operand2_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_operand2_shifter_pipe
//
// Scoreboard bench for operand2_shifter_pipe (WIDTH=32, TAG_W=4). Every
// accepted operation pushes its expected result; a negedge monitor pops and
// compares whenever a downstream transfer happens. Expected values come from
// hand-worked constants or from a behavioural model that applies the ARM
// operand-2 rules bit by bit with loops.
// ---------------------------------------------------------------------------
module tb_operand2_shifter_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int AW    = $clog2(WIDTH);
`ifdef SHIFTER_MID_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] op2;
        logic             c;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic               clk;
    logic               in_Reset;
    logic               in_Valid;
    logic               out_Ready;
    logic [1:0]         in_Mode;
    logic [1:0]         in_Shift_type;
    logic [WIDTH-1:0]   in_Reg_val;
    logic [AW-1:0]      in_Shift_imm;
    logic [7:0]         in_Shift_reg;
    logic [7:0]         in_Imm8;
    logic [3:0]         in_Rotate;
    logic               in_C_flag;
    logic [TAG_W-1:0]   in_Tag;
    logic               out_Valid;
    logic               in_Ready;
    logic [WIDTH-1:0]   out_Op2;
    logic               out_Carry;
    logic [TAG_W-1:0]   out_Tag;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   stallRandom = 0;

    operand2_shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .in_Clk        (clk),
        .in_Reset      (in_Reset),
        .in_Valid      (in_Valid),
        .out_Ready     (out_Ready),
        .in_Mode       (in_Mode),
        .in_Shift_type (in_Shift_type),
        .in_Reg_val    (in_Reg_val),
        .in_Shift_imm  (in_Shift_imm),
        .in_Shift_reg  (in_Shift_reg),
        .in_Imm8       (in_Imm8),
        .in_Rotate     (in_Rotate),
        .in_C_flag     (in_C_flag),
        .in_Tag        (in_Tag),
        .out_Valid     (out_Valid),
        .in_Ready      (in_Ready),
        .out_Op2       (out_Op2),
        .out_Carry     (out_Carry),
        .out_Tag       (out_Tag)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rotate right by m positions, one bit at a time.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int m);
        logic [WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < m; i++) r = {r[0], r[WIDTH-1:1]};
        return r;
    endfunction

    // Shift rules for a plain (already decoded) amount n; returns {carry, result}.
    function automatic logic [WIDTH:0] regRules(input logic [1:0] t, input logic [WIDTH-1:0] r,
                                                input int n, input logic cin);
        logic [WIDTH-1:0] s;
        int m;
        if (n == 0) return {cin, r};
        case (t)
            2'd0: begin
                if (n < WIDTH) begin
                    s = r;
                    for (int i = 0; i < n; i++) s = {s[WIDTH-2:0], 1'b0};
                    return {r[WIDTH-n], s};
                end
                if (n == WIDTH) return {r[0], {WIDTH{1'b0}}};
                return {1'b0, {WIDTH{1'b0}}};
            end
            2'd1: begin
                if (n < WIDTH) begin
                    s = r;
                    for (int i = 0; i < n; i++) s = {1'b0, s[WIDTH-1:1]};
                    return {r[n-1], s};
                end
                if (n == WIDTH) return {r[WIDTH-1], {WIDTH{1'b0}}};
                return {1'b0, {WIDTH{1'b0}}};
            end
            2'd2: begin
                if (n < WIDTH) begin
                    s = r;
                    for (int i = 0; i < n; i++) s = {s[WIDTH-1], s[WIDTH-1:1]};
                    return {r[n-1], s};
                end
                return {r[WIDTH-1], {WIDTH{r[WIDTH-1]}}};
            end
            default: begin
                m = n % WIDTH;
                if (m == 0) return {r[WIDTH-1], r};
                return {r[m-1], rotr(r, m)};
            end
        endcase
    endfunction

    // Full operand-2 reference: returns {carry, result}.
    function automatic logic [WIDTH:0] refModel(input logic [1:0] mode, input logic [1:0] t,
                                                input logic [WIDTH-1:0] r, input int imm,
                                                input int regAmt, input logic [7:0] imm8,
                                                input int rot, input logic cin);
        logic [WIDTH-1:0] v;
        case (mode)
            2'd0: begin
                if (imm != 0) return regRules(t, r, imm, cin);
                case (t)
                    2'd0:    return {cin, r};
                    2'd3:    return {r[0], cin, r[WIDTH-1:1]};
                    default: return regRules(t, r, WIDTH, cin);
                endcase
            end
            2'd1: return regRules(t, r, regAmt, cin);
            2'd2: begin
                v = rotr(WIDTH'(imm8), (2 * rot) % WIDTH);
                return {(rot == 0) ? cin : v[WIDTH-1], v};
            end
            default: return {cin, r};
        endcase
    endfunction

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops the oldest expectation and compares it with the presented result.
    task automatic checkOutput();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_output: got op2=0x%0h tag=%0d expected no output",
                     out_Op2, out_Tag);
            return;
        end
        e = sb.pop_front();
        if (out_Op2 !== e.op2 || out_Carry !== e.c || out_Tag !== e.tag) begin
            bad++;
            $display("[TB] FAIL result_tag%0d: got op2=0x%0h c=%0b tag=%0d expected op2=0x%0h c=%0b tag=%0d",
                     e.tag, out_Op2, out_Carry, out_Tag, e.op2, e.c, e.tag);
        end
    endtask

    // Monitor: a downstream transfer happens at the next rising edge whenever
    // out_Valid and in_Ready are both high mid-cycle.
    always @(negedge clk) begin
        if (!in_Reset && out_Valid && in_Ready) checkOutput();
    end

    // Presents one operation and waits (bounded) for it to be accepted. The
    // expectation is pushed at acceptance, either a given constant or the
    // model's result. Returns one step after the accepting edge.
    task automatic applyStimulus(input logic [1:0] mode, input logic [1:0] t,
                                 input logic [WIDTH-1:0] r, input logic [AW-1:0] imm,
                                 input logic [7:0] regAmt, input logic [7:0] imm8,
                                 input logic [3:0] rot, input logic cin,
                                 input logic [TAG_W-1:0] tag, input bit useExp,
                                 input logic [WIDTH-1:0] expOp2, input logic expC);
        exp_t e;
        logic [WIDTH:0] m;
        bit done;
        in_Mode = mode; in_Shift_type = t; in_Reg_val = r; in_Shift_imm = imm;
        in_Shift_reg = regAmt; in_Imm8 = imm8; in_Rotate = rot; in_C_flag = cin;
        in_Tag = tag; in_Valid = 1'b1;
        done = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (stallRandom) in_Ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_Ready) begin
                if (useExp) begin
                    e.op2 = expOp2; e.c = expC;
                end else begin
                    m = refModel(mode, t, r, int'(imm), int'(regAmt), imm8, int'(rot), cin);
                    e.op2 = m[WIDTH-1:0]; e.c = m[WIDTH];
                end
                e.tag = tag;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_Valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout: got no accept for tag %0d expected accept within 100 cycles", tag);
        end
    endtask

    // Lets the pipeline empty with in_Ready high, bounded.
    task automatic drain(input string name);
        int cyc;
        in_Ready = 1'b1;
        cyc = 0;
        while ((sb.size() != 0) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkValue(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] heldOp2;
        logic [TAG_W-1:0] heldTag;
        int cyc;
        logic [1:0] rm, rt;
        logic [7:0] ramt;
        logic [AW-1:0] rimm;

        in_Reset = 1'b1; in_Valid = 1'b0; in_Ready = 1'b0;
        in_Mode = '0; in_Shift_type = '0; in_Reg_val = '0; in_Shift_imm = '0;
        in_Shift_reg = '0; in_Imm8 = '0; in_Rotate = '0; in_C_flag = 1'b0; in_Tag = '0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_valid", 64'(out_Valid), 64'd0);
        checkValue("reset_op2",   64'(out_Op2),   64'd0);
        checkValue("reset_carry", 64'(out_Carry), 64'd0);
        checkValue("reset_tag",   64'(out_Tag),   64'd0);
        in_Reset = 1'b0;
        in_Ready = 1'b1;
        checkValue("reset_ready", 64'(out_Ready), 64'd1);

        // Directed cases with hand-worked results (WIDTH = 32).
        applyStimulus(2'd1, 2'd0, 32'h2, '0, 8'd33, 8'h0, 4'd0, 1'b1, 4'd1, 1, 32'h0, 1'b0);
        applyStimulus(2'd1, 2'd0, 32'h2, '0, 8'd32, 8'h0, 4'd0, 1'b1, 4'd2, 1, 32'h0, 1'b0);
        applyStimulus(2'd1, 2'd0, 32'h2, '0, 8'd0,  8'h0, 4'd0, 1'b1, 4'd3, 1, 32'h2, 1'b1);
        applyStimulus(2'd0, 2'd3, 32'd200, '0, 8'd0, 8'h0, 4'd0, 1'b1, 4'd4, 1, 32'h80000064, 1'b0);
        applyStimulus(2'd0, 2'd2, 32'h80000000, '0, 8'd0, 8'h0, 4'd0, 1'b0, 4'd5, 1, 32'hFFFFFFFF, 1'b1);
        applyStimulus(2'd2, 2'd0, 32'h0, '0, 8'd0, 8'hFF, 4'd4, 1'b0, 4'd6, 1, 32'hFF000000, 1'b1);
        applyStimulus(2'd2, 2'd0, 32'h0, '0, 8'd0, 8'hFF, 4'd0, 1'b1, 4'd7, 1, 32'h000000FF, 1'b1);
        applyStimulus(2'd1, 2'd1, 32'h80000000, '0, 8'd32, 8'h0, 4'd0, 1'b0, 4'd8, 1, 32'h0, 1'b1);
        applyStimulus(2'd0, 2'd1, 32'h80000000, '0, 8'd0, 8'h0, 4'd0, 1'b0, 4'd9, 1, 32'h0, 1'b1);
        applyStimulus(2'd1, 2'd3, 32'h80000001, '0, 8'd32, 8'h0, 4'd0, 1'b0, 4'd10, 1, 32'h80000001, 1'b1);
        applyStimulus(2'd1, 2'd2, 32'h40000000, '0, 8'd200, 8'h0, 4'd0, 1'b1, 4'd11, 1, 32'h0, 1'b0);
        applyStimulus(2'd1, 2'd0, 32'h80000001, '0, 8'd1, 8'h0, 4'd0, 1'b0, 4'd12, 1, 32'h2, 1'b1);
        applyStimulus(2'd1, 2'd3, 32'h00000003, '0, 8'd33, 8'h0, 4'd0, 1'b0, 4'd13, 1, 32'h80000001, 1'b1);
        applyStimulus(2'd3, 2'd2, 32'hDEADBEEF, '0, 8'd7, 8'h0, 4'd0, 1'b1, 4'd14, 1, 32'hDEADBEEF, 1'b1);
        drain("directed_drained");

        // Latency from the accepting edge to out_Valid, pipeline empty.
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(2'd3, 2'd0, 32'h12345678, '0, 8'd0, 8'h0, 4'd0, 1'b0, 4'd5, 1, 32'h12345678, 1'b0);
        cyc = 1;
        while (!out_Valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkValue("latency", 64'(cyc), 64'(LAT));
        drain("latency_drained");

        // Backpressure: three back-to-back ops into a stalled sink.
        in_Ready = 1'b0;
        fork
            begin
                applyStimulus(2'd3, 2'd0, 32'hAAAA0001, '0, 8'd0, 8'h0, 4'd0, 1'b0, 4'd1, 0, '0, 1'b0);
                applyStimulus(2'd1, 2'd1, 32'hF0F0F0F0, '0, 8'd4, 8'h0, 4'd0, 1'b0, 4'd2, 0, '0, 1'b0);
                applyStimulus(2'd0, 2'd2, 32'h87654321, 5'd8, 8'd0, 8'h0, 4'd0, 1'b0, 4'd3, 0, '0, 1'b0);
            end
            begin
                cyc = 0;
                while (!out_Valid && cyc < 20) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                checkValue("bp_first_valid", 64'(out_Valid), 64'd1);
                heldOp2 = out_Op2;
                heldTag = out_Tag;
                checkValue("bp_first_tag", 64'(heldTag), 64'd1);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    checkValue("bp_hold_valid", 64'(out_Valid), 64'd1);
                    checkValue("bp_hold_op2",   64'(out_Op2),   64'(heldOp2));
                    checkValue("bp_hold_tag",   64'(out_Tag),   64'(heldTag));
                    checkValue("bp_ready_low",  64'(out_Ready), 64'd0);
                end
                in_Ready = 1'b1;
            end
        join
        drain("bp_drained");

        // Asynchronous reset mid-cycle while a result is waiting.
        in_Ready = 1'b0;
        applyStimulus(2'd3, 2'd0, 32'hCAFEF00D, '0, 8'd0, 8'h0, 4'd0, 1'b1, 4'd9, 1, 32'hCAFEF00D, 1'b1);
        cyc = 0;
        while (!out_Valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkValue("rst_pre_valid", 64'(out_Valid), 64'd1);
        #2;
        in_Reset = 1'b1;
        #1;
        checkValue("rst_async_valid", 64'(out_Valid), 64'd0);
        checkValue("rst_async_op2",   64'(out_Op2),   64'd0);
        checkValue("rst_async_carry", 64'(out_Carry), 64'd0);
        checkValue("rst_async_tag",   64'(out_Tag),   64'd0);
        sb.delete();
        @(posedge clk); #1;
        in_Reset = 1'b0;
        in_Ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkValue("rst_no_stale", 64'(out_Valid), 64'd0);
        end
        applyStimulus(2'd1, 2'd1, 32'h000000F0, '0, 8'd4, 8'h0, 4'd0, 1'b0, 4'd6, 1, 32'h0000000F, 1'b0);
        drain("rst_drained");

        // Randomised regression with random downstream stalls.
        stallRandom = 1;
        for (int i = 0; i < 400; i++) begin
            rm = 2'($urandom_range(0, 3));
            rt = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ramt = 8'(WIDTH - 1 + $urandom_range(0, 2));
                1:       ramt = 8'($urandom_range(0, 2));
                default: ramt = 8'($urandom_range(0, 255));
            endcase
            rimm = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, WIDTH - 1));
            applyStimulus(rm, rt, WIDTH'($urandom), rimm, ramt, 8'($urandom_range(0, 255)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          TAG_W'(i), 0, '0, 1'b0);
        end
        stallRandom = 0;
        drain("random_drained");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
